// File: rtl/sid_audio_i2s_tx.sv
// sid_audio_i2s_tx: stereo I2S transmitter for the SID audio path.
// A one-entry pending buffer sits between the SID sample handshake and the
// I2S frame, whose timing is derived from clk via a BCK divider.
// Optional macro SID_I2S_ROUND_EN: round half-up with positive saturation
// when reducing the 24-bit samples to OUT_BITS (default: plain truncation).
module sid_audio_i2s_tx #(
    parameter int BCK_DIV  = 4,
    parameter int OUT_BITS = 24
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               audio_valid_i,
    input  logic signed [23:0] audio_l_i,
    input  logic signed [23:0] audio_r_i,
    output logic               audio_ready_o,
    output logic               i2s_bck_o,
    output logic               i2s_lrck_o,
    output logic               i2s_data_o,
    output logic               underrun_o,
    output logic               overrun_o
);

    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCK_DIV - 1);
    localparam logic [5:0] OB6 = 6'(OUT_BITS);
`ifdef SID_I2S_ROUND_EN
    localparam int RND_SH = (OUT_BITS < 24) ? (23 - OUT_BITS) : 0;
`endif

    // Reduce a 24-bit sample to the transmitted word width.
    function automatic logic [OUT_BITS-1:0] reduce(input logic [23:0] x);
`ifdef SID_I2S_ROUND_EN
        logic [24:0] s;
        if (OUT_BITS >= 24) return x[23 -: OUT_BITS];
        s = {x[23], x} + (25'd1 << RND_SH);
        // Only a positive input can overflow when adding a positive half-LSB.
        if (s[24] != s[23]) return {1'b0, {(OUT_BITS-1){1'b1}}};
        return s[23 -: OUT_BITS];
`else
        return x[23 -: OUT_BITS];
`endif
    endfunction

    logic [DW-1:0]       div_q, div_d;
    logic                bck_q, bck_d;
    logic [5:0]          n_q, n_d;
    logic                lrck_q, lrck_d;
    logic                data_q, data_d;
    logic [OUT_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic [23:0]         pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic                pend_full_q, pend_full_d;
    logic                ur_q, ur_d, ov_q, ov_d;

    logic                wrap, tick, fstart, bit_sel;
    logic [5:0]          n_nx;
    logic [4:0]          k;
    logic [OUT_BITS-1:0] word, sh;

    // Next-state: BCK divider, bit index, serial data and sample buffering.
    always_comb begin
        div_d       = div_q;
        bck_d       = bck_q;
        n_d         = n_q;
        lrck_d      = lrck_q;
        data_d      = data_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pend_full_d = pend_full_q;
        ur_d        = 1'b0;
        ov_d        = 1'b0;
        sh          = '0;
        bit_sel     = 1'b0;

        wrap   = (div_q == DIV_MAX);
        tick   = wrap & bck_q;              // falling BCK edge
        n_nx   = n_q + 6'd1;
        fstart = tick & (n_q == 6'd63);

        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) bck_d = ~bck_q;

        // Slot position 0 is the one-BCK delay; MSB follows at position 1.
        word = n_nx[5] ? act_r_q : act_l_q;
        k    = n_nx[4:0];
        if (k != 5'd0 && {1'b0, k} <= OB6) begin
            sh      = word >> (OB6 - {1'b0, k});
            bit_sel = sh[0];
        end

        if (tick) begin
            n_d    = n_nx;
            lrck_d = n_nx[5];
            data_d = bit_sel;
        end

        // Position 0 transmits 0, so swapping the active words here is safe.
        if (fstart) begin
            if (pend_full_q) begin
                act_l_d     = reduce(pend_l_q);
                act_r_d     = reduce(pend_r_q);
                pend_full_d = audio_valid_i;
                if (audio_valid_i) begin
                    pend_l_d = audio_l_i;
                    pend_r_d = audio_r_i;
                end
            end else if (audio_valid_i) begin
                act_l_d = reduce(audio_l_i);
                act_r_d = reduce(audio_r_i);
            end else begin
                ur_d = 1'b1;
            end
        end else if (audio_valid_i) begin
            ov_d        = pend_full_q;
            pend_l_d    = audio_l_i;
            pend_r_d    = audio_r_i;
            pend_full_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            bck_q       <= 1'b0;
            n_q         <= 6'd63;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pend_full_q <= 1'b0;
            ur_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            div_q       <= div_d;
            bck_q       <= bck_d;
            n_q         <= n_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_full_q <= pend_full_d;
            ur_q        <= ur_d;
            ov_q        <= ov_d;
        end
    end

    assign audio_ready_o = ~pend_full_q;
    assign i2s_bck_o     = bck_q;
    assign i2s_lrck_o    = lrck_q;
    assign i2s_data_o    = data_q;
    assign underrun_o    = ur_q;
    assign overrun_o     = ov_q;

endmodule

// File: tb/tb_sid_audio_i2s_tx.sv
// Scoreboard bench for sid_audio_i2s_tx: a frame-level model predicts the
// words each frame carries and the per-cycle flags; monitors deserialize the
// I2S stream and compare. A second instance covers the 16-bit reduction.
module tb_sid_audio_i2s_tx;
    localparam int D = 4, OB = 24, FRAME = 128 * D;
    localparam int D2 = 2, OB2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid, ready, bck, lrck, data, ur, ov;
    logic signed [23:0] l_in, r_in;
    logic rst2, v2, ready2, bck2, lrck2, data2, ur2, ov2;
    logic signed [23:0] l2, r2;

    int nchk = 0, nerr = 0;

    sid_audio_i2s_tx #(.BCK_DIV(D), .OUT_BITS(OB)) dut (
        .clk_i(clk), .rst_i(rst), .audio_valid_i(valid), .audio_l_i(l_in), .audio_r_i(r_in),
        .audio_ready_o(ready), .i2s_bck_o(bck), .i2s_lrck_o(lrck), .i2s_data_o(data),
        .underrun_o(ur), .overrun_o(ov));

    sid_audio_i2s_tx #(.BCK_DIV(D2), .OUT_BITS(OB2)) dut16 (
        .clk_i(clk), .rst_i(rst2), .audio_valid_i(v2), .audio_l_i(l2), .audio_r_i(r2),
        .audio_ready_o(ready2), .i2s_bck_o(bck2), .i2s_lrck_o(lrck2), .i2s_data_o(data2),
        .underrun_o(ur2), .overrun_o(ov2));

    typedef struct { logic [31:0] l; logic [31:0] r; } fr_t;
    fr_t expq[$];
    fr_t e_fr, p_fr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample reduction from arithmetic on the signed value.
    function automatic logic [31:0] ref_reduce(input logic [23:0] x, input int ob);
        longint v, mx;
        v  = longint'($signed(x));
        mx = (longint'(1) << (ob - 1)) - 1;
`ifdef SID_I2S_ROUND_EN
        if (ob < 24) v = v + (longint'(1) << (23 - ob));
`endif
        v = v >>> (24 - ob);
        if (v > mx) v = mx;
        return 32'(v & ((longint'(1) << ob) - 1));
    endfunction

    // Expected 64-bit frame, bit n = serial bit at index n.
    function automatic logic [63:0] exp_frame(input logic [31:0] wl, input logic [31:0] wr, input int ob);
        logic [63:0] f;
        f = '0;
        for (int k = 1; k <= ob; k++) begin
            f[k]      = wl[ob-k];
            f[32 + k] = wr[ob-k];
        end
        return f;
    endfunction

    // Reference model: frame starts fall at fixed clock counts after reset.
    int c = 0;
    bit pend_full = 0, e_ur = 0, e_ov = 0, rst_seen = 1;
    logic [23:0] pl, pr;
    logic [31:0] al, ar;

    function automatic bit is_fs(input int cc);
        return (cc >= 2 * D - 1) && ((cc - (2 * D - 1)) % FRAME == 0);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            c = 0; pend_full = 0; al = 0; ar = 0; e_ur = 0; e_ov = 0; rst_seen = 1;
            expq.delete();
        end else begin
            rst_seen = 0; e_ur = 0; e_ov = 0;
            if (is_fs(c)) begin
                if (pend_full) begin
                    al = ref_reduce(pl, OB); ar = ref_reduce(pr, OB);
                    pend_full = valid;
                    if (valid) begin pl = l_in; pr = r_in; end
                end else if (valid) begin
                    al = ref_reduce(l_in, OB); ar = ref_reduce(r_in, OB);
                end else begin
                    e_ur = 1;
                end
                p_fr.l = al; p_fr.r = ar;
                expq.push_back(p_fr);
            end else if (valid) begin
                e_ov = pend_full; pl = l_in; pr = r_in; pend_full = 1;
            end
            c++;
        end
    end

    // Monitor for the main instance.
    logic [5:0] m_n = 6'd63;
    int gap = 0;
    bit pb = 0, coll = 0;
    logic [63:0] got;

    initial forever begin
        @(negedge clk);
        if (rst_seen) begin
            chk("reset_outs", {58'd0, bck, lrck, data, ready, ur, ov}, {58'd0, 6'b000100});
            m_n = 6'd63; gap = 0; pb = 0; coll = 0;
        end else begin
            gap++;
            chk("flags", {61'd0, ready, ur, ov}, {61'd0, !pend_full, e_ur, e_ov});
            if (pb && !bck) begin
                chk("bck_period", 64'(gap), 64'(2 * D));
                gap = 0;
                m_n = m_n + 6'd1;
                chk("lrck", {63'd0, lrck}, {63'd0, m_n[5]});
                got[m_n] = data;
                if (m_n == 6'd0) coll = 1;
                if (m_n == 6'd63 && coll) begin
                    if (expq.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL frame_q: got a frame, expected none at %0t", $time);
                    end else begin
                        e_fr = expq.pop_front();
                        chk("frame", got, exp_frame(e_fr.l, e_fr.r, OB));
                    end
                end
            end
            pb = bck;
        end
    end

    // Monitor for the 16-bit instance: first two frames carry the one sample.
    logic [5:0] n2 = 6'd63;
    bit pb2 = 0;
    int f2 = 0;
    logic [63:0] got2;

    initial forever begin
        @(negedge clk);
        if (pb2 && !bck2) begin
            n2 = n2 + 6'd1;
            got2[n2] = data2;
            if (n2 == 6'd63) begin
                if (f2 < 2)
                    chk("reduce16", got2,
                        exp_frame(ref_reduce(24'h7FFFFF, OB2), ref_reduce(24'h1234C0, OB2), OB2));
                f2++;
            end
        end
        pb2 = bck2;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b);
        valid = 1; l_in = a; r_in = b;
        step();
        valid = 0;
    endtask

    task automatic wait_fs();
        int t = 0;
        while (!is_fs(c) && t < 2 * FRAME) begin step(); t++; end
        if (!is_fs(c)) begin
            nchk++; nerr++;
            $display("FAIL wait_fs: got timeout, expected frame start");
        end
    endtask

    initial begin
        int t;
        rst = 1; valid = 0; l_in = 0; r_in = 0;
        rst2 = 1; v2 = 0; l2 = 0; r2 = 0;
        repeat (3) step();
        rst = 0; rst2 = 0;
        v2 = 1; l2 = 24'h7FFFFF; r2 = 24'h1234C0;
        send(24'h800001, 24'h7FFFFE);
        v2 = 0;
        repeat (3 * FRAME) step();              // underrun every frame, same pattern

        wait_fs(); repeat (20) step();          // overrun: A then B 10 clk apart
        send(24'h111111, 24'h222222);
        repeat (9) step();
        send(24'h333333, 24'h444444);

        wait_fs(); step(); wait_fs();           // valid coincident with frame start
        send(24'hABCDEF, 24'h012345);
        repeat (2 * FRAME) step();

        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 199) == 0) send(24'($urandom), 24'($urandom));
            else step();
        end

        t = 0;                                   // reset in the middle of a frame
        while (m_n != 6'd40 && t < 2 * FRAME) begin step(); t++; end
        if (m_n != 6'd40) begin
            nchk++; nerr++;
            $display("FAIL wait_n40: got timeout, expected n=40");
        end
        rst = 1; step(); rst = 0;
        send(24'h5A5A5A, 24'hA5A5A5);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) send(24'($urandom), 24'($urandom));
            else step();
        end
        repeat (FRAME) step();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sid_audio_i2s_tx.md
# sid_audio_i2s_tx

I2S transmitter that serializes the filtered, volume-scaled SID audio samples into a stereo I2S stream for the external audio DAC. It sits downstream of the filter/mixer stage and consumes one stereo sample per SID sample period through a valid/ready handshake. A one-entry pending buffer decouples the SID sample rate from the I2S frame rate, which is derived from the system clock.

## Interface
- `BCK_DIV`, default 4: clk cycles per BCK half-period (legal range 1..255); BCK = clk/(2*BCK_DIV).
- `OUT_BITS`, default 24: sample bits transmitted per slot (legal range 16..24); the remaining slot bits are zero.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `audio_valid` in 1: a stereo sample is presented; it is accepted unconditionally in that cycle.
- `audio_l` in 24: left sample, signed (`sid::s24_t`).
- `audio_r` in 24: right sample, signed (`sid::s24_t`).
- `audio_ready` out 1: high when the pending buffer is empty.
- `i2s_bck` out 1: bit clock.
- `i2s_lrck` out 1: word select; 0 = left, 1 = right.
- `i2s_data` out 1: serial data, MSB first, Philips I2S alignment.
- `underrun` out 1: one-cycle pulse; a frame started with no new sample.
- `overrun` out 1: one-cycle pulse; the pending sample was overwritten before it was consumed.

## Operation
- Divider counter counts 0..BCK_DIV-1. `i2s_bck` toggles when the counter wraps. A falling BCK edge is a "tick".
- 6-bit bit index `n` (0..63) advances on each tick and wraps 63→0. Reset sets `n` = 63, so the first tick starts a frame at `n` = 0.
- `i2s_lrck` = `n[5]`, updated on the tick.
- Slot position `k` = `n mod 32`, channel = `n[5]`.
  - `k` = 0: `i2s_data` = 0.
  - `k` in 1..OUT_BITS: `i2s_data` = bit (OUT_BITS-`k`) of the active word for that channel.
  - Otherwise: `i2s_data` = 0.
  - This gives the standard one-BCK MSB delay after each LRCK edge.
- Active word per channel: the 24-bit input reduced to OUT_BITS (see Configuration). When OUT_BITS = 24 it is the input unchanged.
- Frame start (tick with `n` wrapping to 0) loads the active samples:
  - Pending full: pending → active; pending becomes empty.
  - Pending empty and `audio_valid` high in the same cycle: input → active directly. No flags.
  - Pending empty, no valid: active is retained and `underrun` pulses.
- `audio_valid` outside a frame-start load:
  - Pending empty: input → pending.
  - Pending full: input overwrites pending and `overrun` pulses.
- Pending full at frame start with simultaneous `audio_valid`: pending → active, input → pending. No overrun.
- Reset values:
  - Outputs: `i2s_bck` = 0, `i2s_lrck` = 0, `i2s_data` = 0, `audio_ready` = 1, `underrun` = 0, `overrun` = 0.
  - Internal state: active samples = 0, pending empty, divider = 0, `n` = 63.
- Reset asserted mid-frame aborts the frame immediately. All state returns to its reset values in the next cycle.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- BCK period = 2*BCK_DIV clk. Frame = 64 BCK = 128*BCK_DIV clk (512 clk at the default).
- First BCK rising edge occurs BCK_DIV clk after reset release. The first tick (frame start) occurs 2*BCK_DIV clk after reset release.
- `i2s_lrck` and `i2s_data` change in the same cycle as the BCK falling edge. They are stable for the full BCK high phase.
- Latency, input to pin: a sample accepted before frame start F has its left MSB on `i2s_data` at the tick of `n` = 1 in frame F.
- `audio_ready` reflects pending state registered in the previous cycle. It returns high the cycle after the frame-start load.
- `underrun` and `overrun` are high for exactly one clk.

## Configuration
- `SID_I2S_ROUND_EN` defined: reduction to OUT_BITS rounds half-up by adding 1 << (23-OUT_BITS) before truncation. The result saturates to the signed OUT_BITS maximum on positive overflow. No effect when OUT_BITS = 24.
- `SID_I2S_ROUND_EN` undefined: plain truncation, keeping input bits [23 -: OUT_BITS].

## Test plan
- Reset, BCK_DIV = 4, left = 24'h800001, right = 24'h7FFFFE, one valid pulse:
  - BCK period is 8 clk and `i2s_lrck` toggles every 256 clk.
  - Left slot bits 1..24 are 1000…0001; right slot bits 1..24 are 0111…1110; pad bits and bit 0 are 0.
- No `audio_valid` after the first sample: `underrun` pulses once per frame, and the same bit pattern repeats every frame.
- Two valid pulses 10 clk apart within one frame (A then B): `overrun` pulses once, and the next frame transmits B.
- `audio_valid` coincident with frame start and pending empty: that sample is transmitted in the same frame, with no `underrun` and no `overrun`.
- OUT_BITS = 16, input 24'h7FFFFF:
  - With `SID_I2S_ROUND_EN`: transmitted 16'h7FFF (saturated).
  - Without: 16'h7FFF. Input 24'h1234C0 gives 16'h1235 with the macro and 16'h1234 without.
- `rst` asserted at `n` = 40 for 1 clk: the next cycle shows all outputs at their reset values, and a new frame starts 2*BCK_DIV clk later.
